// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down counter and its control stage.
package counter_pkg;

  localparam int COUNTER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, debounce counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      pulse <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Level held long enough: accept it; only a press (not a release) pulses.
        stable <= s;
        cnt    <= '0;
        pulse  <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause and direction control for the 4-bit up/down counter, with an
// optional auto-reverse that ping-pongs the count between its limits.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH           = COUNTER_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_VAL         = 15,
  parameter int MIN_VAL         = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_dir,
  input  logic             auto_rev,
  input  logic [WIDTH-1:0] count,
  output logic             en,
  output logic             dir,
  output logic             turn,
  output logic [1:0]       state
);

  // Turn one step early: the counter has already advanced by the time dir lands.
  localparam logic [WIDTH-1:0] HI_TURN = WIDTH'(MAX_VAL - 1);
  localparam logic [WIDTH-1:0] LO_TURN = WIDTH'(MIN_VAL + 1);

  ctrl_state_t state_q;
  ctrl_state_t state_n;
  logic        run_pulse;
  logic        dir_pulse;
  logic        en_n;
  logic        dir_n;
  logic        turn_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_run),
    .pulse (run_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dir),
    .pulse (dir_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en      <= 1'b0;
      dir     <= 1'b1;
      turn    <= 1'b0;
    end else begin
      state_q <= state_n;
      en      <= en_n;
      dir     <= dir_n;
      turn    <= turn_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (run_pulse) state_n = RUN;
      RUN:     if (run_pulse) state_n = PAUSE;
      PAUSE:   if (run_pulse) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    en_n   = (state_n == RUN);
    dir_n  = dir;
    turn_n = 1'b0;
    // Auto-reverse outranks a coincident direction press, which is dropped.
    if (auto_rev && (state_q == RUN) && dir && (count >= HI_TURN)) begin
      dir_n  = 1'b0;
      turn_n = 1'b1;
    end else if (auto_rev && (state_q == RUN) && !dir && (count <= LO_TURN)) begin
      dir_n  = 1'b1;
      turn_n = 1'b1;
    end else if (dir_pulse) begin
      dir_n = ~dir;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Closed-loop bench for counter_ctrl: behavioural counter model, directed
// button stimulus, and a scoreboard of expected output changes.
module tb_counter_ctrl;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_dir = 1'b0;
  logic       auto_rev = 1'b0;
  logic [3:0] count;
  logic       en;
  logic       dir;
  logic       turn;
  logic [1:0] state;

  logic       load = 1'b1;
  logic [3:0] load_val = 4'd0;
  int         errors = 0;
  int         checks = 0;
  bit         mon_on = 1'b0;

  typedef struct {
    string      name;
    logic       en;
    logic       dir;
    logic       turn;
    logic [1:0] st;
    bit         chk_cnt;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  counter_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_dir  (btn_dir),
    .auto_rev (auto_rev),
    .count    (count),
    .en       (en),
    .dir      (dir),
    .turn     (turn),
    .state    (state)
  );

  // Counter being controlled; load lets the bench preset a start value.
  always @(posedge clk) begin
    if (load) count <= load_val;
    else if (en) count <= dir ? count + 4'd1 : count - 4'd1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input string name, input logic e, input logic d, input logic t,
                           input logic [1:0] st, input bit cc = 1'b0, input logic [3:0] c = 4'd0);
    exp_t x;
    x.name = name; x.en = e; x.dir = d; x.turn = t; x.st = st; x.chk_cnt = cc; x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic press(input bit is_dir, input int n);
    if (is_dir) btn_dir = 1'b1;
    else btn_run = 1'b1;
    cyc(n);
    btn_dir = 1'b0;
    btn_run = 1'b0;
  endtask

  // Press for 10 cycles; the watched output must hold through E5 and flip at E6.
  task automatic press_timed(input bit is_dir, input string name);
    logic old_v;
    old_v = is_dir ? dir : en;
    if (is_dir) btn_dir = 1'b1;
    else btn_run = 1'b1;
    cyc(6);
    check({name, "_pre_e6"}, {4'b0, (is_dir ? dir : en)}, {4'b0, old_v});
    cyc(1);
    check({name, "_at_e6"}, {4'b0, (is_dir ? dir : en)}, {4'b0, ~old_v});
    cyc(3);
    btn_dir = 1'b0;
    btn_run = 1'b0;
    cyc(8);
  endtask

  task automatic wait_count(input logic [3:0] c, input logic d, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (count == c && dir == d) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: count=%0d dir=%b never seen, expected within 100 cycles", name, c, d);
    end
  endtask

  // Monitor: every change of en/dir/turn/state must match the next expectation.
  initial begin
    logic [4:0] last;
    logic [4:0] cur;
    exp_t       x;
    wait (mon_on);
    last = {en, dir, turn, state};
    forever begin
      @(negedge clk);
      cur = {en, dir, turn, state};
      if (cur !== last) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got en,dir,turn,state=%b count=%0d, expected no change",
                   cur, count);
        end else begin
          x = sb.pop_front();
          if (cur !== {x.en, x.dir, x.turn, x.st} || (x.chk_cnt && count !== x.cnt)) begin
            errors++;
            $display("FAIL %s: got en,dir,turn,state=%b count=%0d, expected %b count=%0d",
                     x.name, cur, count, {x.en, x.dir, x.turn, x.st}, x.cnt);
          end
        end
        last = cur;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    check("reset_values", {en, dir, turn, state}, 5'b01000);
    rst = 1'b0;
    load = 1'b0;
    mon_on = 1'b1;
    cyc(5);
    check("idle_after_reset", {en, dir, turn, state}, 5'b01000);

    btn_run = 1'b1; cyc(3); btn_run = 1'b0; cyc(12);
    check("glitch_rejected", {en, dir, turn, state}, 5'b01000);

    expect_ev("idle_to_run", 1'b1, 1'b1, 1'b0, RUN);
    press_timed(1'b0, "run_en");

    expect_ev("run_to_pause", 1'b0, 1'b1, 1'b0, PAUSE);
    press(1'b0, 10); cyc(8);

    expect_ev("bounce_then_run", 1'b1, 1'b1, 1'b0, RUN);
    btn_run = 1'b1; cyc(1); btn_run = 1'b0; cyc(1);
    btn_run = 1'b1; cyc(1); btn_run = 1'b0; cyc(1);
    press(1'b0, 10); cyc(8);

    expect_ev("dir_toggle_run", 1'b1, 1'b0, 1'b0, RUN);
    press_timed(1'b1, "dir_run");

    expect_ev("pause_dir_down", 1'b0, 1'b0, 1'b0, PAUSE);
    press(1'b0, 10); cyc(8);
    expect_ev("dir_in_pause", 1'b0, 1'b1, 1'b0, PAUSE);
    press(1'b1, 10); cyc(8);
    expect_ev("resume_dir_held", 1'b1, 1'b1, 1'b0, RUN);
    press(1'b0, 10); cyc(8);
    check("dir_held_on_resume", {3'b0, en, dir}, 5'b00011);

    expect_ev("pause_for_load", 1'b0, 1'b1, 1'b0, PAUSE);
    press(1'b0, 10); cyc(8);
    load_val = 4'd10; load = 1'b1; cyc(1); load = 1'b0;
    auto_rev = 1'b1;
    expect_ev("ar_resume",   1'b1, 1'b1, 1'b0, RUN, 1'b1, 4'd10);
    expect_ev("ar_top_turn", 1'b1, 1'b0, 1'b1, RUN, 1'b1, 4'd15);
    expect_ev("ar_top_down", 1'b1, 1'b0, 1'b0, RUN, 1'b1, 4'd14);
    expect_ev("ar_bot_turn", 1'b1, 1'b1, 1'b1, RUN, 1'b1, 4'd0);
    expect_ev("ar_bot_up",   1'b1, 1'b1, 1'b0, RUN, 1'b1, 4'd1);
    press(1'b0, 10);
    wait_count(4'd1, 1'b1, "wait_bottom");
    // Dir press timed so its pulse lands on the edge that sees count 14.
    expect_ev("ar_prio_turn", 1'b1, 1'b0, 1'b1, RUN, 1'b1, 4'd15);
    expect_ev("ar_prio_down", 1'b1, 1'b0, 1'b0, RUN, 1'b1, 4'd14);
    cyc(7);
    press(1'b1, 10);
    wait_count(4'd5, 1'b0, "wait_down5");
    auto_rev = 1'b0;
    check("prio_dir_stays_down", {en, dir, turn, state}, 5'b10001);
    cyc(8);

    expect_ev("dir_up_again", 1'b1, 1'b1, 1'b0, RUN);
    press(1'b1, 10); cyc(8);
    expect_ev("late_ar_turn", 1'b1, 1'b0, 1'b1, RUN, 1'b1, 4'd0);
    expect_ev("late_ar_wrap", 1'b1, 1'b0, 1'b0, RUN, 1'b1, 4'd15);
    wait_count(4'd15, 1'b1, "wait_top");
    auto_rev = 1'b1; cyc(1); auto_rev = 1'b0; cyc(3);

    expect_ev("mid_reset", 1'b0, 1'b1, 1'b0, IDLE);
    btn_run = 1'b1; cyc(3);
    rst = 1'b1; btn_run = 1'b0; cyc(1);
    rst = 1'b0; cyc(20);
    check("no_press_after_reset", {en, dir, turn, state}, 5'b01000);

    cyc(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
